// File: rtl/trig_seq_ctrl.sv
// Trigger sequencer: walks a 4-entry {cycle, delay, trig_num, gap} table and drives the trigger
// delay controller. Define TRIG_SEQ_TIMEOUT_EN to enable the WAIT-state timeout (timeout_err).
//
// state | meaning
// IDLE  | waiting for an accepted start
// LOAD  | register table[cur_idx] onto cfg_*
// FIRE  | trig_out high for FIRE_LEN cycles
// WAIT  | count core_done pulses up to trig_num
// GAP   | inter-entry pause, then next entry / loop / done
module trig_seq_ctrl #(
  parameter logic [31:0] TO_LIMIT = 32'd100_000_000,
  parameter int unsigned FIRE_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        loop_en,
  input  logic [2:0]  seq_len,
  input  logic        tbl_wr_en,
  input  logic [1:0]  tbl_wr_addr,
  input  logic [1:0]  tbl_wr_sel,
  input  logic [31:0] tbl_wr_data,
  input  logic        core_done,
  output logic [31:0] cfg_camera_cycle,
  output logic [31:0] cfg_camera_delay,
  output logic [31:0] cfg_camera_trig_num,
  output logic        trig_out,
  output logic        busy,
  output logic [1:0]  cur_idx,
  output logic        seq_done,
  output logic        timeout_err
);

`ifdef TRIG_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT, GAP} state_t;
  state_t state_q, state_d;

  logic [31:0] tbl [4][4];
  logic [31:0] gap_q, cnt_q, cnt_d, done_q, done_d;
  logic [31:0] cnt_inc, done_inc, num_eff, gap_eff;
  logic [3:0]  fire_q, fire_d;
  logic [2:0]  len_q, len_d;
  logic [1:0]  idx_d;
  logic        trig_d, seq_done_d, to_err_d, load_cfg;

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < 4; a++)
        for (int s = 0; s < 4; s++)
          tbl[a][s] <= '0;
    end else if (tbl_wr_en) begin
      tbl[tbl_wr_addr][tbl_wr_sel] <= tbl_wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = cur_idx;
    len_d      = len_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    fire_d     = fire_q;
    trig_d     = 1'b0;
    seq_done_d = 1'b0;
    to_err_d   = timeout_err;
    load_cfg   = 1'b0;
    // counters saturate instead of wrapping
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;
    done_inc = (done_q == '1) ? done_q : done_q + 32'd1;
    num_eff  = (cfg_camera_trig_num == '0) ? 32'd1 : cfg_camera_trig_num;
    gap_eff  = (gap_q == '0) ? 32'd1 : gap_q;

    case (state_q)
      IDLE: begin
        if (start && seq_len != 3'd0 && seq_len <= 3'd4) begin
          len_d    = seq_len;
          idx_d    = '0;
          to_err_d = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        load_cfg = 1'b1;
        cnt_d    = '0;
        done_d   = '0;
        fire_d   = '0;
        trig_d   = 1'b1;
        state_d  = FIRE;
      end
      FIRE: begin
        if (fire_q >= 4'(FIRE_LEN - 1)) begin
          state_d = WAIT;
        end else begin
          fire_d = fire_q + 4'd1;
          trig_d = 1'b1;
        end
      end
      WAIT: begin
        cnt_d = cnt_inc;
        if (core_done) done_d = done_inc;
        if (core_done && done_inc >= num_eff) begin
          cnt_d   = '0;
          state_d = GAP;
        end else if (TO_EN && cnt_inc >= TO_LIMIT) begin
          to_err_d = 1'b1;
          state_d  = IDLE;
        end
      end
      GAP: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= gap_eff) begin
          cnt_d = '0;
          if ({1'b0, cur_idx} < len_q - 3'd1) begin
            idx_d   = cur_idx + 2'd1;
            state_d = LOAD;
          end else if (loop_en) begin
            idx_d   = '0;
            state_d = LOAD;
          end else begin
            seq_done_d = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // abort wins over everything, including a same-cycle start
    if (abort) begin
      state_d    = IDLE;
      idx_d      = cur_idx;
      len_d      = len_q;
      to_err_d   = timeout_err;
      trig_d     = 1'b0;
      seq_done_d = 1'b0;
      load_cfg   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q               <= '0;
      done_q              <= '0;
      fire_q              <= '0;
      len_q               <= '0;
      gap_q               <= '0;
      cur_idx             <= '0;
      trig_out            <= 1'b0;
      seq_done            <= 1'b0;
      timeout_err         <= 1'b0;
      cfg_camera_cycle    <= '0;
      cfg_camera_delay    <= '0;
      cfg_camera_trig_num <= '0;
    end else begin
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      fire_q      <= fire_d;
      len_q       <= len_d;
      cur_idx     <= idx_d;
      trig_out    <= trig_d;
      seq_done    <= seq_done_d;
      timeout_err <= TO_EN & to_err_d;
      if (load_cfg) begin
        cfg_camera_cycle    <= tbl[cur_idx][0];
        cfg_camera_delay    <= tbl[cur_idx][1];
        cfg_camera_trig_num <= tbl[cur_idx][2];
        gap_q               <= tbl[cur_idx][3];
      end
    end
  end

endmodule

// File: tb/tb_trig_seq_ctrl.sv
// Scoreboard bench for trig_seq_ctrl: directed sequences push expected trigger/done/timeout
// events; a forked monitor pops and compares them as the DUT produces them.
module tb_trig_seq_ctrl;
  localparam int FL = 4;
  localparam int LIM = 400;
  localparam logic [7:0] KT = "T";
  localparam logic [7:0] KD = "D";
  localparam logic [7:0] KE = "E";

  logic        clk = 1'b0;
  logic        rst, start, abort, loop_en, tbl_wr_en, core_done;
  logic [2:0]  seq_len;
  logic [1:0]  tbl_wr_addr, tbl_wr_sel, cur_idx;
  logic [31:0] tbl_wr_data, cfg_camera_cycle, cfg_camera_delay, cfg_camera_trig_num;
  logic        trig_out, busy, seq_done, timeout_err;

  typedef struct {
    logic [7:0] kind;
    int idx, cyc, dly, num, dt;
  } ev_t;
  ev_t exp_q[$];

  int n_tests = 0;
  int n_fails = 0;
  int cyc = 0;
  int last_cyc = 0;

  trig_seq_ctrl #(.TO_LIMIT(32'd50), .FIRE_LEN(FL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop_en(loop_en),
    .seq_len(seq_len), .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr),
    .tbl_wr_sel(tbl_wr_sel), .tbl_wr_data(tbl_wr_data), .core_done(core_done),
    .cfg_camera_cycle(cfg_camera_cycle), .cfg_camera_delay(cfg_camera_delay),
    .cfg_camera_trig_num(cfg_camera_trig_num), .trig_out(trig_out), .busy(busy),
    .cur_idx(cur_idx), .seq_done(seq_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_tests++;
    n_fails++;
    $display("FAIL %s: wait bound expired before the DUT responded", nm);
  endtask

  task automatic expect_ev(input logic [7:0] k, input int idx, input int c, input int d,
                           input int n, input int dt);
    ev_t e;
    e.kind = k; e.idx = idx; e.cyc = c; e.dly = d; e.num = n; e.dt = dt;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input logic [7:0] k);
    ev_t e;
    int dt;
    dt = cyc - last_cyc;
    last_cyc = cyc;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fails++;
      $display("FAIL unexpected_event: got %c idx %0d cycle %0d, expected no event", k, cur_idx,
               cfg_camera_cycle);
    end else begin
      e = exp_q.pop_front();
      if (k != e.kind || int'(cur_idx) != e.idx || cfg_camera_cycle != e.cyc ||
          cfg_camera_delay != e.dly || cfg_camera_trig_num != e.num || (e.dt >= 0 && dt != e.dt)) begin
        n_fails++;
        $display("FAIL event_%c: got %c idx %0d cfg %0d/%0d/%0d dt %0d, expected %c idx %0d cfg %0d/%0d/%0d dt %0d",
                 e.kind, k, cur_idx, cfg_camera_cycle, cfg_camera_delay, cfg_camera_trig_num, dt,
                 e.kind, e.idx, e.cyc, e.dly, e.num, e.dt);
      end
    end
  endtask

  task automatic monitor();
    bit   in_pulse = 1'b0;
    int   width = 0;
    logic to_prev = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        in_pulse = 1'b0;
      end else begin
        if (trig_out && !in_pulse) begin
          in_pulse = 1'b1;
          width = 1;
          got_ev(KT);
        end else if (trig_out) begin
          width++;
        end else if (in_pulse) begin
          in_pulse = 1'b0;
          chk("trig_width", width, FL);
        end
        if (seq_done) got_ev(KD);
        if (timeout_err && !to_prev) got_ev(KE);
      end
      to_prev = timeout_err;
    end
  endtask

  task automatic wr(input int a, input int s, input int d);
    tbl_wr_en = 1'b1; tbl_wr_addr = 2'(a); tbl_wr_sel = 2'(s); tbl_wr_data = d;
    @(negedge clk);
    tbl_wr_en = 1'b0;
  endtask

  task automatic wr_entry(input int a, input int c, input int d, input int n, input int g);
    wr(a, 0, c); wr(a, 1, d); wr(a, 2, n); wr(a, 3, g);
  endtask

  task automatic do_start(input logic [2:0] len);
    seq_len = len; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // returns on the first sample after a trig_out pulse, i.e. the first WAIT cycle
  task automatic wait_fire_end(input string nm);
    int k = 0;
    while (trig_out !== 1'b1 && k < LIM) begin @(negedge clk); k++; end
    while (trig_out === 1'b1 && k < LIM) begin @(negedge clk); k++; end
    if (k >= LIM) bound_fail(nm);
  endtask

  task automatic done_pulses(input int n);
    for (int i = 0; i < n; i++) begin core_done = 1'b1; @(negedge clk); end
    core_done = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy === 1'b1 && k < LIM) begin @(negedge clk); k++; end
    if (k >= LIM) bound_fail(nm);
  endtask

  initial begin
    int k;
    rst = 1'b1; start = 1'b0; abort = 1'b0; loop_en = 1'b0; seq_len = 3'd1;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_sel = '0; tbl_wr_data = '0; core_done = 1'b0;
    fork monitor(); join_none
    repeat (2) @(negedge clk);
    chk("rst_trig", trig_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_cycle", cfg_camera_cycle, 0);
    chk("rst_idx", cur_idx, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // single entry, two core_done, gap 5
    wr_entry(0, 100, 10, 2, 5);
    expect_ev(KT, 0, 100, 10, 2, -1);
    expect_ev(KD, 0, 100, 10, 2, FL + 2 + 5);
    do_start(3'd1);
    chk("t1_busy", busy, 1);
    chk("t1_trig", trig_out, 0);
    @(negedge clk);
    chk("t2_trig", trig_out, 1);
    chk("t2_cfg_cycle", cfg_camera_cycle, 100);
    wait_fire_end("s1_fire");
    done_pulses(2);
    wait_idle("s1_idle");
    chk("s1_busy_end", busy, 0);
    repeat (3) @(negedge clk);

    // three entries; start while busy with seq_len 1 must be ignored
    wr_entry(0, 200, 20, 1, 0);
    wr_entry(1, 201, 21, 1, 1);
    wr_entry(2, 202, 22, 1, 3);
    expect_ev(KT, 0, 200, 20, 1, -1);
    expect_ev(KT, 1, 201, 21, 1, FL + 1 + 1 + 1);
    expect_ev(KT, 2, 202, 22, 1, FL + 1 + 1 + 1);
    expect_ev(KD, 2, 202, 22, 1, FL + 1 + 3);
    do_start(3'd3);
    wait_fire_end("s3_e0");
    done_pulses(1);
    wait_fire_end("s3_e1");
    seq_len = 3'd1; start = 1'b1; core_done = 1'b1;
    @(negedge clk);
    start = 1'b0; core_done = 1'b0;
    chk("start_busy_idx", cur_idx, 1);
    wait_fire_end("s3_e2");
    done_pulses(1);
    wait_idle("s3_idle");
    repeat (3) @(negedge clk);

    // ignored starts
    do_start(3'd0);
    chk("len0_busy", busy, 0);
    do_start(3'd5);
    chk("len5_busy", busy, 0);
    seq_len = 3'd1; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    repeat (2) @(negedge clk);

    // looping two entries, abort in WAIT
    loop_en = 1'b1;
    expect_ev(KT, 0, 200, 20, 1, -1);
    expect_ev(KT, 1, 201, 21, 1, FL + 1 + 1 + 1);
    expect_ev(KT, 0, 200, 20, 1, FL + 1 + 1 + 1);
    expect_ev(KT, 1, 201, 21, 1, FL + 1 + 1 + 1);
    do_start(3'd2);
    for (int i = 0; i < 3; i++) begin
      wait_fire_end("loop_fire");
      done_pulses(1);
    end
    wait_fire_end("loop_last");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    loop_en = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_trig", trig_out, 0);
    chk("abort_cfg_kept", cfg_camera_cycle, 201);
    repeat (15) @(negedge clk);

`ifdef TRIG_SEQ_TIMEOUT_EN
    expect_ev(KT, 0, 200, 20, 1, -1);
    expect_ev(KE, 0, 200, 20, 1, FL + 50);
    do_start(3'd1);
    wait_fire_end("to_fire");
    wait_idle("to_idle");
    chk("to_err_set", timeout_err, 1);
    expect_ev(KT, 0, 200, 20, 1, -1);
    expect_ev(KD, 0, 200, 20, 1, FL + 1 + 1);
    do_start(3'd1);
    chk("to_err_cleared", timeout_err, 0);
    wait_fire_end("to2_fire");
    done_pulses(1);
    wait_idle("to2_idle");
`else
    expect_ev(KT, 0, 200, 20, 1, -1);
    do_start(3'd1);
    wait_fire_end("nto_fire");
    repeat (60) @(negedge clk);
    chk("nto_busy", busy, 1);
    chk("nto_err", timeout_err, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("nto_abort_busy", busy, 0);
`endif
    repeat (3) @(negedge clk);

    // reset during FIRE, then run from the cleared table
    expect_ev(KT, 0, 200, 20, 1, -1);
    do_start(3'd1);
    k = 0;
    while (trig_out !== 1'b1 && k < LIM) begin @(negedge clk); k++; end
    if (k >= LIM) bound_fail("rst_fire");
    #2 rst = 1'b1;
    #1;
    chk("rstf_trig", trig_out, 0);
    chk("rstf_busy", busy, 0);
    chk("rstf_cfg", cfg_camera_cycle, 0);
    chk("rstf_done", seq_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", busy, 0);
    expect_ev(KT, 0, 0, 0, 0, -1);
    expect_ev(KD, 0, 0, 0, 0, FL + 1 + 1);
    do_start(3'd1);
    wait_fire_end("z_fire");
    done_pulses(1);
    wait_idle("z_idle");
    repeat (5) @(negedge clk);

    chk("events_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
